change_dispenser: RTL

Coin-return controller on the output side of the vending machine. It accepts change requests from the vending machine's `change[1:0]` output and queues them. For each request it drives the hopper motor once per 5-unit coin owed and confirms each coin with the drop sensor. A coin that never drops within a bounded time raises a sticky fault.

---
 rtl/change_dispenser.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: coin-return controller on the output side of the vending
// machine. Change requests are captured on the 0 -> nonzero transition of the
// change code, queued in a small circular FIFO, and paid out one 5-unit coin at
// a time: each coin is one fixed-width hopper pulse followed by a wait for the
// drop sensor. A coin that never drops parks the block in a sticky FAULT state
// that only reset clears.
// Build option: define CHANGE_DISP_RETRY_EN to allow one extra hopper pulse per
// coin before a drop timeout is treated as a fault.

module change_dispenser #(
  parameter int PULSE_CYC   = 4,   // hopper pulse width in cycles (>= 1)
  parameter int TIMEOUT_CYC = 64,  // max WAIT cycles without a drop (>= 2)
  parameter int DEPTH       = 4    // request queue depth (power of two, >= 2)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] change,
  input  logic       coin_seen,
  output logic       hopper_on,
  output logic       busy,
  output logic       dispensed,
  output logic       q_full,
  output logic       fault
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_MAX = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         change_prev_q, change_prev_d;  // registered change code
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         remaining_q, remaining_d;
  logic               pend_q, pend_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               hopper_on_q, hopper_on_d;
  logic               busy_q, busy_d;
  logic               dispensed_q, dispensed_d;
  logic               q_full_q, q_full_d;
  logic               fault_q, fault_d;
`ifdef CHANGE_DISP_RETRY_EN
  logic               retry_used_q, retry_used_d;
`endif

  logic [1:0]         mem_q [DEPTH];
  logic               req_edge;
  logic               pop;
  logic               do_push;

  // Next-state logic: request capture, queue bookkeeping, payout FSM, outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree can leave it unassigned and infer a latch.
    change_prev_d = change;
    state_d       = state_q;
    remaining_d   = remaining_q;
    pend_d        = pend_q;
    timer_d       = timer_q;
    pop           = 1'b0;
`ifdef CHANGE_DISP_RETRY_EN
    retry_used_d  = retry_used_q;
`endif

    req_edge = (change != 2'd0) && (change_prev_q == 2'd0);

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          remaining_d = mem_q[rd_ptr_q];
          pend_d      = 1'b0;
          timer_d     = '0;
          state_d     = S_PULSE;
`ifdef CHANGE_DISP_RETRY_EN
          retry_used_d = 1'b0;
`endif
        end
      end
      S_PULSE: begin
        // A drop during the pulse is remembered and counted in WAIT; a second
        // drop in the same window finds pend already set and is lost.
        if (coin_seen) pend_d = 1'b1;
        if (timer_q == PULSE_LAST) begin
          timer_d = '0;
          state_d = S_WAIT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WAIT: begin
        if (coin_seen || pend_q) begin
          pend_d  = 1'b0;
          timer_d = '0;
          if (remaining_q != 2'd0) remaining_d = remaining_q - 2'd1;
          state_d = (remaining_q <= 2'd1) ? S_DONE : S_PULSE;
`ifdef CHANGE_DISP_RETRY_EN
          retry_used_d = 1'b0;
`endif
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
`ifdef CHANGE_DISP_RETRY_EN
          if (!retry_used_q) begin
            retry_used_d = 1'b1;
            state_d      = S_PULSE;
          end else begin
            state_d = S_FAULT;
          end
`else
          state_d = S_FAULT;
`endif
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // A full queue only accepts a request when the head leaves on the same edge.
    do_push  = req_edge && ((count_q != DEPTH_C) || pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(pop);

    // Outputs are decoded from next state so they leave the block as flops.
    hopper_on_d = (state_d == S_PULSE);
    busy_d      = (state_d != S_IDLE) || (count_d != '0);
    dispensed_d = (state_d == S_DONE);
    q_full_d    = (count_d == DEPTH_C);
    fault_d     = (state_d == S_FAULT);
  end

  // Control and output registers; reset stops the hopper and empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, regardless of statement order.
    if (!rst) begin
      state_q       <= S_IDLE;
      change_prev_q <= 2'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      remaining_q   <= 2'd0;
      pend_q        <= 1'b0;
      timer_q       <= '0;
      hopper_on_q   <= 1'b0;
      busy_q        <= 1'b0;
      dispensed_q   <= 1'b0;
      q_full_q      <= 1'b0;
      fault_q       <= 1'b0;
`ifdef CHANGE_DISP_RETRY_EN
      retry_used_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      change_prev_q <= change_prev_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      remaining_q   <= remaining_d;
      pend_q        <= pend_d;
      timer_q       <= timer_d;
      hopper_on_q   <= hopper_on_d;
      busy_q        <= busy_d;
      dispensed_q   <= dispensed_d;
      q_full_q      <= q_full_d;
      fault_q       <= fault_d;
`ifdef CHANGE_DISP_RETRY_EN
      retry_used_q  <= retry_used_d;
`endif
    end
  end

  // Queue storage: written on accepted requests only.
  always_ff @(posedge clk) begin
    // NOTE: the entries are deliberately not reset; the pointers and count are,
    // and an entry is never read before it has been written.
    if (do_push) mem_q[wr_ptr_q] <= change;
  end

  assign hopper_on = hopper_on_q;
  assign busy      = busy_q;
  assign dispensed = dispensed_q;
  assign q_full    = q_full_q;
  assign fault     = fault_q;

endmodule
